// File: rtl/lower_mem_responder.sv
// lower_mem_responder
//   Memory end of the shared snoop bus. Serves line fills (BusRd/BusRdX)
//   after a fixed read latency and an arbiter grant, and commits write-backs
//   (Mem_wr) after a fixed write latency. A pending fill is dropped when a
//   snooper holding the line in M state supplies it instead (Mem_oprn_abort).
//
// Ports
//   clk, rst        : clock, asynchronous active-high reset
//   BusRd, BusRdX   : fill requests (treated identically)
//   Address_Com     : transaction address, low MEM_AW bits index the array
//   Mem_wr          : write-back request, data taken from Data_Bus_Com
//   Mem_oprn_abort  : cancel the pending fill
//   Mem_snoop_gnt   : arbiter grant of the data bus
//   Mem_snoop_req   : request for the data bus
//   Mem_write_done  : one-cycle pulse when a write-back is committed
//   Data_Bus_Com    : shared data bus, driven only while returning fill data
//   Data_in_Bus     : data-valid strobe, driven 1 only while returning data
module lower_mem_responder #(
    parameter int ADDRESSSIZE = 32,
    parameter int MEM_AW      = 8,
    parameter int RD_LAT      = 4,
    parameter int WR_LAT      = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   BusRd,
    input  logic                   BusRdX,
    input  logic [ADDRESSSIZE-1:0] Address_Com,
    input  logic                   Mem_wr,
    input  logic                   Mem_oprn_abort,
    input  logic                   Mem_snoop_gnt,
    output logic                   Mem_snoop_req,
    output logic                   Mem_write_done,
    inout  wire  [ADDRESSSIZE-1:0] Data_Bus_Com,
    inout  wire                    Data_in_Bus
);

    localparam int DEPTH = 2 ** MEM_AW;

    localparam logic [2:0] IDLE      = 3'd0;
    localparam logic [2:0] RD_WAIT   = 3'd1;
    localparam logic [2:0] RD_REQ    = 3'd2;
    localparam logic [2:0] RD_DRIVE  = 3'd3;
    localparam logic [2:0] WR_WAIT   = 3'd4;
    localparam logic [2:0] WR_COMMIT = 3'd5;
    localparam logic [2:0] DONE      = 3'd6;

    logic [2:0]             state;
    logic [3:0]             counter;
    logic [MEM_AW-1:0]      idx;
    logic [ADDRESSSIZE-1:0] wdata;
    logic                   after_rd;   // DONE was entered from a read path
    logic [ADDRESSSIZE-1:0] mem [DEPTH];

    logic any_rd;
    logic wr_start;
    logic rd_start;

    // Upper address bits alias onto the low index and are never looked at.
    logic unused_addr_hi;
    assign unused_addr_hi = ^Address_Com[ADDRESSSIZE-1:MEM_AW];

    assign any_rd = BusRd | BusRdX;

    // A write may also start from DONE after a read: that is the snooper
    // write-back that follows an aborted fill while the fill request is
    // still held. After a write, a held Mem_wr must not restart anything.
    assign wr_start = Mem_wr && (state == IDLE || (state == DONE && after_rd));
    assign rd_start = (state == IDLE) && !Mem_wr && any_rd;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= IDLE;
            counter        <= '0;
            idx            <= '0;
            wdata          <= '0;
            after_rd       <= 1'b0;
            Mem_snoop_req  <= 1'b0;
            Mem_write_done <= 1'b0;
        end else begin
            Mem_write_done <= 1'b0;
            if (wr_start) begin
                idx      <= Address_Com[MEM_AW-1:0];
                wdata    <= Data_Bus_Com;
                counter  <= 4'(WR_LAT - 1);
                after_rd <= 1'b0;
                state    <= WR_WAIT;
            end else if (rd_start) begin
                idx     <= Address_Com[MEM_AW-1:0];
                counter <= 4'(RD_LAT - 1);
                state   <= RD_WAIT;
            end else begin
                case (state)
                    RD_WAIT: begin
                        if (Mem_oprn_abort) begin
                            after_rd <= 1'b1;
                            state    <= DONE;
                        end else if (counter == '0) begin
                            Mem_snoop_req <= 1'b1;
                            state         <= RD_REQ;
                        end else begin
                            counter <= counter - 4'd1;
                        end
                    end
                    RD_REQ: begin
                        // Abort wins over a same-cycle grant: the snooper owns
                        // the data phase.
                        if (Mem_oprn_abort) begin
                            Mem_snoop_req <= 1'b0;
                            after_rd      <= 1'b1;
                            state         <= DONE;
                        end else if (Mem_snoop_gnt) begin
                            Mem_snoop_req <= 1'b0;
                            state         <= RD_DRIVE;
                        end
                    end
                    RD_DRIVE: begin
                        after_rd <= 1'b1;
                        state    <= DONE;
                    end
                    WR_WAIT: begin
                        if (counter == '0) state <= WR_COMMIT;
                        else               counter <= counter - 4'd1;
                    end
                    WR_COMMIT: begin
                        Mem_write_done <= 1'b1;
                        state          <= DONE;
                    end
                    DONE: begin
                        if (!any_rd && !Mem_wr) state <= IDLE;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    // Storage: each word resets to its own index and is written in WR_COMMIT.
    for (genvar g = 0; g < DEPTH; g++) begin : g_word
        always_ff @(posedge clk or posedge rst) begin
            if (rst)
                mem[g] <= ADDRESSSIZE'(g);
            else if (state == WR_COMMIT && idx == MEM_AW'(g))
                mem[g] <= wdata;
        end
    end

    // Bus drivers decode straight from state so the data phase is exactly
    // the single RD_DRIVE cycle.
    assign Data_Bus_Com = (state == RD_DRIVE) ? mem[idx] : {ADDRESSSIZE{1'bz}};
    assign Data_in_Bus  = (state == RD_DRIVE) ? 1'b1 : 1'bz;

endmodule

// File: tb/tb_lower_mem_responder.sv
module tb_lower_mem_responder;
    localparam int RD_LAT = 4;
    localparam int WR_LAT = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        BusRd, BusRdX, Mem_wr, Mem_oprn_abort, Mem_snoop_gnt;
    logic [31:0] Address_Com;
    logic        Mem_snoop_req, Mem_write_done;
    wire  [31:0] Data_Bus_Com;
    wire         Data_in_Bus;
    logic        tb_drv;
    logic [31:0] tb_data;

    assign Data_Bus_Com = tb_drv ? tb_data : 32'hzzzz_zzzz;

    lower_mem_responder #(
        .ADDRESSSIZE(32), .MEM_AW(8), .RD_LAT(RD_LAT), .WR_LAT(WR_LAT)
    ) dut (
        .clk(clk), .rst(rst), .BusRd(BusRd), .BusRdX(BusRdX),
        .Address_Com(Address_Com), .Mem_wr(Mem_wr),
        .Mem_oprn_abort(Mem_oprn_abort), .Mem_snoop_gnt(Mem_snoop_gnt),
        .Mem_snoop_req(Mem_snoop_req), .Mem_write_done(Mem_write_done),
        .Data_Bus_Com(Data_Bus_Com), .Data_in_Bus(Data_in_Bus)
    );

    always #5 clk = ~clk;

    int          errors = 0;
    int          checks = 0;
    logic [31:0] mdl [256];
    logic [31:0] exp_q [$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic mdl_reset();
        for (int i = 0; i < 256; i++) mdl[i] = 32'(i);
    endtask

    function automatic logic strobe();
        return (Data_in_Bus === 1'b1);
    endfunction

    // Called at the first negedge after acceptance; returns edges to req.
    task automatic wait_req(output int k);
        k = 0;
        while (Mem_snoop_req !== 1'b1 && k < 60) begin
            @(negedge clk);
            k++;
        end
    endtask

    task automatic rd_txn(input string tag, input logic [31:0] addr, input bit rdx,
                          input int gnt_delay);
        int k, bad;
        logic [31:0] e;
        logic [7:0]  ix;
        ix = addr[7:0];
        exp_q.push_back(mdl[ix]);
        @(negedge clk);
        BusRd = !rdx; BusRdX = rdx; Address_Com = addr;
        @(negedge clk);
        BusRd = 1'b0; BusRdX = 1'b0;
        wait_req(k);
        chk({tag, "_req_lat"}, k, RD_LAT);
        bad = 0;
        for (int j = 0; j < gnt_delay; j++) begin
            @(negedge clk);
            if (Mem_snoop_req !== 1'b1 || strobe()) bad++;
        end
        chk({tag, "_gnt_hold"}, bad, 0);
        Mem_snoop_gnt = 1'b1;
        @(negedge clk);
        Mem_snoop_gnt = 1'b0;
        chk({tag, "_strobe"}, strobe(), 1'b1);
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hx;
        if (strobe()) chk({tag, "_data"}, Data_Bus_Com, e);
        chk({tag, "_req_drop"}, Mem_snoop_req, 1'b0);
        @(negedge clk);
        chk({tag, "_strobe_1cyc"}, strobe(), 1'b0);
    endtask

    task automatic wr_txn(input string tag, input logic [31:0] addr, input logic [31:0] data,
                          input bit with_rd);
        int k;
        logic [7:0] ix;
        ix = addr[7:0];
        @(negedge clk);
        Mem_wr = 1'b1; Address_Com = addr; tb_data = data; tb_drv = 1'b1;
        if (with_rd) BusRd = 1'b1;
        @(negedge clk);
        Mem_wr = 1'b0; tb_drv = 1'b0;
        k = 0;
        while (Mem_write_done !== 1'b1 && k < 60) begin
            @(negedge clk);
            k++;
        end
        chk({tag, "_done_lat"}, k, WR_LAT + 1);
        mdl[ix] = data;
        @(negedge clk);
        chk({tag, "_done_1cyc"}, Mem_write_done, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int k, bad;
        rst = 1'b1; BusRd = 0; BusRdX = 0; Mem_wr = 0; Mem_oprn_abort = 0;
        Mem_snoop_gnt = 0; Address_Com = '0; tb_drv = 0; tb_data = '0;
        mdl_reset();
        @(negedge clk); @(negedge clk);
        chk("rst_req", Mem_snoop_req, 1'b0);
        chk("rst_done", Mem_write_done, 1'b0);
        chk("rst_strobe", strobe(), 1'b0);
        rst = 1'b0;

        // 1: basic fill of a reset word
        rd_txn("t1", 32'h0000_0005, 1'b0, 0);

        // 2: write-back then BusRdX of the same word
        wr_txn("t2", 32'h0000_0012, 32'hDEAD_BEEF, 1'b0);
        rd_txn("t2", 32'h0000_0012, 1'b1, 0);

        // 3: abort in RD_REQ, then snooper write-back while BusRd still held
        @(negedge clk);
        BusRd = 1'b1; Address_Com = 32'h20;
        @(negedge clk);
        wait_req(k);
        chk("t3_req_lat", k, RD_LAT);
        Mem_oprn_abort = 1'b1;
        @(negedge clk);
        Mem_oprn_abort = 1'b0;
        chk("t3_req_drop", Mem_snoop_req, 1'b0);
        bad = 0;
        for (int j = 0; j < 3; j++) begin
            @(negedge clk);
            if (strobe() || Mem_snoop_req === 1'b1) bad++;
        end
        chk("t3_no_drive", bad, 0);
        wr_txn("t3", 32'h20, 32'hCAFE_0001, 1'b0);
        bad = 0;
        for (int j = 0; j < 6; j++) begin
            @(negedge clk);
            if (strobe() || Mem_snoop_req === 1'b1 || Mem_write_done === 1'b1) bad++;
        end
        chk("t3_no_retrigger", bad, 0);
        BusRd = 1'b0;
        rd_txn("t3", 32'h20, 1'b0, 0);

        // 4: read and write together -> write first, read never starts
        wr_txn("t4", 32'h33, 32'h1234_5678, 1'b1);
        bad = 0;
        for (int j = 0; j < 8; j++) begin
            @(negedge clk);
            if (Mem_snoop_req === 1'b1 || strobe()) bad++;
        end
        chk("t4_no_read", bad, 0);
        BusRd = 1'b0;
        rd_txn("t4", 32'h33, 1'b0, 0);

        // 5: reset in RD_REQ and in WR_WAIT
        @(negedge clk);
        BusRd = 1'b1; Address_Com = 32'h40;
        @(negedge clk);
        BusRd = 1'b0;
        wait_req(k);
        chk("t5_req_lat", k, RD_LAT);
        rst = 1'b1;
        #1;
        chk("t5_rst_req", Mem_snoop_req, 1'b0);
        chk("t5_rst_strobe", strobe(), 1'b0);
        mdl_reset();
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        Mem_wr = 1'b1; Address_Com = 32'h41; tb_data = 32'hAAAA_5555; tb_drv = 1'b1;
        @(negedge clk);
        Mem_wr = 1'b0; tb_drv = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("t5_rst_done", Mem_write_done, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        bad = 0;
        for (int j = 0; j < 8; j++) begin
            @(negedge clk);
            if (Mem_write_done === 1'b1 || strobe()) bad++;
        end
        chk("t5_no_done", bad, 0);
        rd_txn("t5a", 32'h41, 1'b0, 0);
        rd_txn("t5b", 32'h12, 1'b1, 0);

        // 6: long grant wait, plus address aliasing on the low index bits
        rd_txn("t6", 32'hFFFF_FF05, 1'b0, 20);
        wr_txn("t6", 32'h0000_1377, 32'h0BAD_F00D, 1'b0);
        rd_txn("t6_alias", 32'hABCD_0077, 1'b1, 3);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
